// File: rtl/speed_period_counter.sv
// Hall-edge period counter: prescaled timebase, saturating tick count, capture on edge.
// Optional stall report and stalled flag compiled in with SPEED_PERIOD_STALL_EN.
module speed_period_counter #(
    parameter int WIDTH    = 16,
    parameter int PRESCALE = 435
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic             hall_edge,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    output logic             overflow,
    output logic             stalled
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PS_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] MAX     = '1;
    localparam logic [WIDTH-1:0] MAX_M1  = MAX - WIDTH'(1);

    logic [PW-1:0] prescaler;
    logic          tick_event;
    logic          capture;

    assign tick_event = enable && (prescaler == PS_LAST);
    assign capture    = enable && hall_edge;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prescaler    <= '0;
            count        <= '0;
            tick         <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            tick         <= 1'b0;
            if (clear) begin
                prescaler <= '0;
                count     <= '0;
                overflow  <= 1'b0;
            end else if (capture) begin
                // Pre-increment value is captured; a coincident tick is dropped.
                period       <= count;
                period_valid <= 1'b1;
                prescaler    <= '0;
                count        <= '0;
                overflow     <= 1'b0;
            end else if (enable) begin
                tick <= tick_event;
                if (tick_event) begin
                    prescaler <= '0;
                    if (count == MAX) begin
                        overflow <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
`ifdef SPEED_PERIOD_STALL_EN
                    // Reaching MAX happens once per restart, so one report per stall.
                    if (count == MAX_M1) begin
                        period       <= MAX;
                        period_valid <= 1'b1;
                    end
`endif
                end else begin
                    prescaler <= prescaler + 1'b1;
                end
            end
        end
    end

`ifdef SPEED_PERIOD_STALL_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stalled <= 1'b0;
        end else if (clear || capture) begin
            stalled <= 1'b0;
        end else if (tick_event && count == MAX_M1) begin
            stalled <= 1'b1;
        end
    end
`else
    assign stalled = 1'b0;

    logic unused_max_m1;
    assign unused_max_m1 = ^MAX_M1;
`endif

endmodule

// File: tb/tb_speed_period_counter.sv
// Self-checking bench for speed_period_counter (WIDTH=8, PRESCALE=4).
// Directed vector table, hand sequences and random traffic against a cycle-count model.
module tb_speed_period_counter;

    localparam int W   = 8;
    localparam int P   = 4;
    localparam int MAX = 255;

    logic         clock;
    logic         reset;
    logic         enable;
    logic         clear;
    logic         hall_edge;
    logic [W-1:0] count;
    logic         tick;
    logic [W-1:0] period;
    logic         period_valid;
    logic         overflow;
    logic         stalled;

    speed_period_counter #(.WIDTH(W), .PRESCALE(P)) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .clear        (clear),
        .hall_edge    (hall_edge),
        .count        (count),
        .tick         (tick),
        .period       (period),
        .period_valid (period_valid),
        .overflow     (overflow),
        .stalled      (stalled)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int checks = 0;
    int errors = 0;

    // Model: enabled cycles elapsed since the last restart.
    longint n;
    int     m_period;
    bit     m_pv, m_tick, m_ov, m_st;

    function automatic int m_count();
        return (n / P > MAX) ? MAX : int'(n / P);
    endfunction

    task automatic model_reset();
        n = 0; m_period = 0; m_pv = 0; m_tick = 0; m_ov = 0; m_st = 0;
    endtask

    task automatic model_step(input bit en, input bit clr, input bit he);
        m_pv   = 0;
        m_tick = 0;
        if (clr) begin
            n = 0; m_ov = 0; m_st = 0;
        end else if (en && he) begin
            m_period = m_count();
            m_pv = 1; n = 0; m_ov = 0; m_st = 0;
        end else if (en) begin
            n++;
            if (n % P == 0) begin
                m_tick = 1;
                if (n / P > MAX) m_ov = 1;
`ifdef SPEED_PERIOD_STALL_EN
                if (n / P == MAX) begin
                    m_period = MAX; m_pv = 1; m_st = 1;
                end
`endif
            end
        end
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("count",        count,        m_count());
        chk("tick",         tick,         m_tick);
        chk("period",       period,       m_period);
        chk("period_valid", period_valid, m_pv);
        chk("overflow",     overflow,     m_ov);
        chk("stalled",      stalled,      m_st);
    endtask

    task automatic step(input bit en, input bit clr, input bit he);
        enable = en; clear = clr; hall_edge = he;
        @(posedge clock);
        #1;
        model_step(en, clr, he);
        compare_model();
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step(1, 0, 0);
    endtask

    typedef struct {
        bit en, clr, he;
        int cnt, per;
        bit pv, tk;
    } vec_t;

    vec_t vecs[23];
    int   pv_seen;
    int   pv_per;
    bit   en_r, clr_r, he_r;

    initial begin
        vecs[0]  = '{1, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{1, 0, 0, 0, 0, 0, 0};
        vecs[2]  = '{1, 0, 0, 0, 0, 0, 0};
        vecs[3]  = '{1, 0, 0, 1, 0, 0, 1};
        vecs[4]  = '{1, 0, 0, 1, 0, 0, 0};
        vecs[5]  = '{1, 0, 1, 0, 1, 1, 0};
        vecs[6]  = '{1, 0, 1, 0, 0, 1, 0};
        vecs[7]  = '{0, 0, 1, 0, 0, 0, 0};
        vecs[8]  = '{1, 0, 0, 0, 0, 0, 0};
        vecs[9]  = '{1, 0, 0, 0, 0, 0, 0};
        vecs[10] = '{1, 0, 0, 0, 0, 0, 0};
        vecs[11] = '{1, 0, 0, 1, 0, 0, 1};
        vecs[12] = '{0, 0, 0, 1, 0, 0, 0};
        vecs[13] = '{1, 0, 1, 0, 1, 1, 0};
        vecs[14] = '{1, 0, 0, 0, 1, 0, 0};
        vecs[15] = '{1, 0, 0, 0, 1, 0, 0};
        vecs[16] = '{1, 0, 0, 0, 1, 0, 0};
        vecs[17] = '{1, 0, 0, 1, 1, 0, 1};
        vecs[18] = '{1, 1, 1, 0, 1, 0, 0};
        vecs[19] = '{1, 0, 0, 0, 1, 0, 0};
        vecs[20] = '{1, 0, 0, 0, 1, 0, 0};
        vecs[21] = '{1, 0, 0, 0, 1, 0, 0};
        vecs[22] = '{1, 0, 0, 1, 1, 0, 1};

        reset = 1'b1; enable = 1'b0; clear = 1'b0; hall_edge = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        compare_model();
        reset = 1'b0;

        // Directed vector table
        foreach (vecs[i]) begin
            step(vecs[i].en, vecs[i].clr, vecs[i].he);
            chk("vec count",        count,        vecs[i].cnt);
            chk("vec period",       period,       vecs[i].per);
            chk("vec period_valid", period_valid, vecs[i].pv);
            chk("vec tick",         tick,         vecs[i].tk);
        end

        // Basic measurement: 40 enabled cycles between edges
        step(1, 0, 1);
        run(40);
        chk("basic count before edge", count, 10);
        step(1, 0, 1);
        chk("basic period", period, 10);
        chk("basic valid", period_valid, 1);
        chk("basic count restart", count, 0);
        step(1, 0, 0);
        chk("basic valid one cycle", period_valid, 0);

        // Enable freeze with an ignored edge in the window
        run(20);
        for (int i = 0; i < 20; i++) step(0, 0, (i == 10));
        chk("freeze no valid", period_valid, 0);
        chk("freeze count held", count, 5);
        run(20);
        step(1, 0, 1);
        chk("freeze period", period, 10);

        // Coincident tick: capture on the cycle that would tick 9 -> 10
        run(39);
        chk("coincident pre count", count, 9);
        step(1, 0, 1);
        chk("coincident period", period, 9);
        chk("coincident count", count, 0);

        // Collision: clear beats hall_edge
        run(12);
        step(1, 1, 1);
        chk("collision period", period, 9);
        chk("collision valid", period_valid, 0);
        chk("collision count", count, 0);

        // Saturation
        step(1, 0, 1);
        pv_seen = 0;
        pv_per  = -1;
        for (int i = 0; i < 1100; i++) begin
            step(1, 0, 0);
            if (period_valid) begin
                pv_seen++;
                pv_per = period;
            end
        end
        chk("sat count", count, MAX);
        chk("sat overflow", overflow, 1);
`ifdef SPEED_PERIOD_STALL_EN
        chk("sat reports", pv_seen, 1);
        chk("sat report period", pv_per, MAX);
        chk("sat stalled", stalled, 1);
`else
        chk("sat reports", pv_seen, 0);
        chk("sat stalled", stalled, 0);
`endif
        step(1, 0, 1);
        chk("sat capture period", period, MAX);
        chk("sat capture valid", period_valid, 1);
        chk("sat overflow cleared", overflow, 0);
        chk("sat stalled cleared", stalled, 0);

        // Asynchronous reset mid-measurement with count=37
        run(148);
        chk("pre-reset count", count, 37);
        #3 reset = 1'b1;
        #1;
        chk("async count", count, 0);
        chk("async period", period, 0);
        chk("async tick", tick, 0);
        chk("async valid", period_valid, 0);
        chk("async overflow", overflow, 0);
        chk("async stalled", stalled, 0);
        model_reset();
        @(posedge clock);
        #2 reset = 1'b0;
        for (int i = 0; i < 6; i++) step(0, 0, (i == 2));
        chk("idle count", count, 0);

        // Random traffic, then a slow-edge phase that reaches saturation
        for (int i = 0; i < 3000; i++) begin
            en_r  = ($urandom_range(0, 9) != 0);
            clr_r = ($urandom_range(0, 199) == 0);
            he_r  = ($urandom_range(0, 59) == 0);
            step(en_r, clr_r, he_r);
        end
        for (int i = 0; i < 4000; i++) begin
            en_r  = ($urandom_range(0, 15) != 0);
            clr_r = ($urandom_range(0, 2999) == 0);
            he_r  = ($urandom_range(0, 1499) == 0);
            step(en_r, clr_r, he_r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/speed_period_counter.md
# speed_period_counter

Parametrised period-measurement counter for the BLDC speed path. A programmable prescaler divides the system clock into timebase ticks. A saturating tick counter measures the interval between successive hall-sensor edge pulses. Each edge captures the interval into a holding register with a one-cycle valid strobe for the downstream speed calculation.

## Interface
Parameters:
- WIDTH, 16, width of the tick counter and the captured period.
- PRESCALE, 435, clock cycles per timebase tick; legal range 1 to 65535.

Ports:
- clock, input, 1, system clock; all logic on its rising edge.
- reset, input, 1, asynchronous, active-high reset.
- enable, input, 1, when high, the prescaler runs and hall_edge is honoured.
- clear, input, 1, synchronous restart of the measurement.
- hall_edge, input, 1, single-cycle pulse marking a commutation edge; already synchronised and edge-detected upstream.
- count, output, WIDTH, live tick count since the last restart.
- tick, output, 1, registered one-cycle timebase pulse.
- period, output, WIDTH, last captured interval in ticks.
- period_valid, output, 1, one-cycle strobe: period has just been updated.
- overflow, output, 1, sticky flag: a tick arrived while count was saturated.
- stalled, output, 1, stall indication; see Configuration.

## Operation
- Prescaler (internal, ceil(log2(PRESCALE)) bits, minimum 1):
  - Counts 0 to PRESCALE-1 while enable=1, then wraps.
  - tick is asserted in the cycle after the prescaler equals PRESCALE-1.
  - PRESCALE=1 gives a tick on every enabled cycle.
- Tick counter:
  - Increments by 1 on each internal tick event.
  - Saturates at MAX = 2^WIDTH-1.
  - A tick event while count==MAX sets overflow.
- Capture happens when hall_edge=1 and enable=1:
  - period <= count, using the pre-increment value. A coincident tick is discarded.
  - period_valid <= 1 for one cycle.
  - count, prescaler and overflow are all set to 0.
  - With the feature compiled in, stalled is also set to 0.
- Clear (clear=1, enable ignored):
  - count, prescaler, overflow and stalled are set to 0.
  - period is held and period_valid stays 0.
- Priority, highest first: reset, clear, capture, tick/increment.
- enable=0 behaviour:
  - The prescaler and count freeze and no tick is issued.
  - hall_edge is ignored; no capture and no valid strobe.
- Reset value of every output is 0: count, tick, period, period_valid, overflow, stalled.
- Reset mid-measurement discards the count and the held period immediately (asynchronously).

## Timing
- Capture latency: 1 cycle. period and period_valid change on the clock edge that samples hall_edge=1.
- After a restart (capture, clear or reset release) with enable held high:
  - The first internal tick event occurs at the PRESCALE-th enabled cycle.
  - After N enabled cycles, count = min(floor(N/PRESCALE), MAX).
- Back-to-back hall_edge on consecutive cycles:
  - The second capture yields period=0.
  - period_valid is high for two cycles.
- overflow is set one cycle after the first tick at saturation. It remains set until capture, clear or reset.

## Configuration
- Macro: SPEED_PERIOD_STALL_EN.
- Defined:
  - When count transitions from MAX-1 to MAX, the block emits exactly one unsolicited report: period <= MAX, period_valid pulses once, and stalled <= 1.
  - stalled holds until the next capture, clear or reset.
  - The report fires only once per stall.
  - If hall_edge coincides with that transition, the normal capture wins: period = MAX-1 and stalled stays 0.
- Undefined:
  - stalled is tied to 0.
  - No unsolicited report is made; period only updates on hall_edge.

## Test plan
All scenarios use WIDTH=8 and PRESCALE=4.
- Reset and idle: assert reset asynchronously mid-cycle with count=37 -> all outputs are 0 immediately and remain 0 with enable=0.
- Basic measurement: enable=1; hall_edge pulses, then pulses again exactly 40 enabled cycles later -> period=10, period_valid high for 1 cycle, count restarts at 0.
- Enable freeze: start a measurement, drop enable for 20 cycles mid-count and pulse hall_edge during that window, then re-enable -> no capture occurs and the next capture excludes the 20 frozen cycles.
- Saturation: no hall_edge for 1100 enabled cycles ->
  - count=255 and overflow=1.
  - With SPEED_PERIOD_STALL_EN: exactly one period_valid with period=255 and stalled=1.
  - A later hall_edge -> period=255 again, and overflow and stalled clear.
- Collision: clear and hall_edge in the same cycle -> period unchanged, no period_valid, count=0.
- Coincident tick: hall_edge in the same cycle as an internal tick event with count=9 -> period=9 and count=0 on the next cycle.
